// File: rtl/wino_pad_bridge.sv
`default_nettype none
// ============================================================================
// Module      : wino_pad_bridge
// Description : Pad-side bridge for the Winograd core. Deserialises narrow
//               pad beats into D tiles (valid/ready toward the core) and
//               buffers Z result tiles in a small FIFO, serialising them back
//               onto narrow output pads with a last-beat marker.
// Revision    : 1.0 - initial release
// ============================================================================
module wino_pad_bridge #(
    parameter int DW        = 10,
    parameter int N_IN      = 6,
    parameter int N_OUT     = 2,
    parameter int PIN_W     = 20,
    parameter int POUT_W    = 10,
    parameter int OUT_DEPTH = 2,
    parameter int CNT_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  in_valid,
    input  logic [PIN_W-1:0]      in_data,
    output logic                  in_ready,
    output logic [DW*N_IN-1:0]    d_tile,
    output logic                  d_valid,
    input  logic                  d_ready,
    input  logic [DW*N_OUT-1:0]   z_tile,
    input  logic                  z_valid,
    output logic                  z_ready,
    output logic [POUT_W-1:0]     out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic [CNT_W-1:0]      in_tile_cnt,
    output logic [CNT_W-1:0]      out_tile_cnt
);

    localparam int c_IN_BEATS  = DW * N_IN / PIN_W;
    localparam int c_OUT_BEATS = DW * N_OUT / POUT_W;
    localparam int c_IN_CW     = (c_IN_BEATS > 1) ? $clog2(c_IN_BEATS) : 1;
    localparam int c_OUT_CW    = (c_OUT_BEATS > 1) ? $clog2(c_OUT_BEATS) : 1;
    localparam int c_AW        = $clog2(OUT_DEPTH);

    localparam logic [c_IN_CW-1:0]  c_IN_LAST  = c_IN_CW'(c_IN_BEATS - 1);
    localparam logic [c_OUT_CW-1:0] c_OUT_LAST = c_OUT_CW'(c_OUT_BEATS - 1);

    // ------------------------------------------------------------------
    // Input side: collect beats, then hold the tile until the core takes it
    // ------------------------------------------------------------------
    typedef enum logic [0:0] {
        S_COLLECT = 1'b0,
        S_HOLD    = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   w_in_fire;
    logic                   w_d_fire;
    logic [c_IN_CW-1:0]     r_in_beat;
    logic [DW*N_IN-1:0]     r_d_tile;
    logic [CNT_W-1:0]       r_in_cnt;

    // Input FSM state register; clr forces a return to COLLECT
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_COLLECT;
        end else if (clr) begin
            r_state <= S_COLLECT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Input FSM next state and handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        d_valid     = 1'b0;
        w_in_fire   = 1'b0;
        w_d_fire    = 1'b0;
        case (r_state)
            S_COLLECT: begin
                in_ready  = 1'b1;
                w_in_fire = in_valid;
                if (in_valid && (r_in_beat == c_IN_LAST)) begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                d_valid  = 1'b1;
                w_d_fire = d_ready;
                if (d_ready) begin
                    w_state_nxt = S_COLLECT;
                end
            end
            default: begin
                w_state_nxt = S_COLLECT;
            end
        endcase
    end

    // Beat assembly (LSB-first) and delivered-tile counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_in_beat <= '0;
            r_d_tile  <= '0;
            r_in_cnt  <= '0;
        end else if (clr) begin
            r_in_beat <= '0;
            r_d_tile  <= '0;
            r_in_cnt  <= '0;
        end else begin
            if (w_in_fire) begin
                for (int k = 0; k < c_IN_BEATS; k++) begin
                    if (r_in_beat == c_IN_CW'(k)) begin
                        r_d_tile[k*PIN_W +: PIN_W] <= in_data;
                    end
                end
                r_in_beat <= (r_in_beat == c_IN_LAST) ? '0 : r_in_beat + 1'b1;
            end
            if (w_d_fire) begin
                r_in_beat <= '0;
                r_in_cnt  <= r_in_cnt + 1'b1;
            end
        end
    end

    assign d_tile      = r_d_tile;
    assign in_tile_cnt = r_in_cnt;

    // ------------------------------------------------------------------
    // Output side: tile FIFO plus beat serialiser on the head entry
    // ------------------------------------------------------------------
    logic [DW*N_OUT-1:0]    r_mem [OUT_DEPTH];
    logic [c_AW:0]          r_wr_ptr;
    logic [c_AW:0]          r_rd_ptr;
    logic [c_OUT_CW-1:0]    r_out_beat;
    logic [CNT_W-1:0]       r_out_cnt;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_push;
    logic                   w_beat_fire;
    logic                   w_pop;
    logic [DW*N_OUT-1:0]    w_head;

    // Extra pointer MSB separates the full case from the empty case
    assign w_full      = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                         (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign w_empty     = (r_wr_ptr == r_rd_ptr);
    assign z_ready     = !w_full;
    assign out_valid   = !w_empty;
    assign w_push      = z_valid && !w_full && !clr;
    assign w_beat_fire = out_valid && out_ready;
    assign w_pop       = w_beat_fire && (r_out_beat == c_OUT_LAST);
    assign w_head      = r_mem[r_rd_ptr[c_AW-1:0]];

    // FIFO storage; contents are only observed while the entry is live
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= z_tile;
        end
    end

    // FIFO pointers, output beat counter and sent-tile counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_out_beat <= '0;
            r_out_cnt  <= '0;
        end else if (clr) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_out_beat <= '0;
            r_out_cnt  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_beat_fire) begin
                if (w_pop) begin
                    r_out_beat <= '0;
                    r_rd_ptr   <= r_rd_ptr + 1'b1;
                    r_out_cnt  <= r_out_cnt + 1'b1;
                end else begin
                    r_out_beat <= r_out_beat + 1'b1;
                end
            end
        end
    end

    // Select the current beat of the head tile; idle pads read as zero
    always_comb begin
        out_data = '0;
        out_last = 1'b0;
        if (!w_empty) begin
            for (int k = 0; k < c_OUT_BEATS; k++) begin
                if (r_out_beat == c_OUT_CW'(k)) begin
                    out_data = w_head[k*POUT_W +: POUT_W];
                end
            end
            out_last = (r_out_beat == c_OUT_LAST);
        end
    end

    assign out_tile_cnt = r_out_cnt;

endmodule
`default_nettype wire

// File: tb/tb_wino_pad_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_wino_pad_bridge
// Description : Self-checking bench for wino_pad_bridge. A queue-based
//               reference model tracks tiles and beats; a second instance
//               with a 2-bit counter checks counter wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wino_pad_bridge;

    localparam int DW        = 10;
    localparam int N_IN      = 6;
    localparam int N_OUT     = 2;
    localparam int PIN_W     = 20;
    localparam int POUT_W    = 10;
    localparam int OUT_DEPTH = 2;
    localparam int CNT_W     = 16;
    localparam int IN_BEATS  = DW * N_IN / PIN_W;
    localparam int OUT_BEATS = DW * N_OUT / POUT_W;

    logic                 clk;
    logic                 rst;
    logic                 clr;
    logic                 in_valid;
    logic [PIN_W-1:0]     in_data;
    logic                 in_ready;
    logic [DW*N_IN-1:0]   d_tile;
    logic                 d_valid;
    logic                 d_ready;
    logic [DW*N_OUT-1:0]  z_tile;
    logic                 z_valid;
    logic                 z_ready;
    logic [POUT_W-1:0]    out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_last;
    logic [CNT_W-1:0]     in_tile_cnt;
    logic [CNT_W-1:0]     out_tile_cnt;

    // second instance, only its wrapping counter is of interest
    logic                 w2_in_ready;
    logic [DW*N_IN-1:0]   w2_d_tile;
    logic                 w2_d_valid;
    logic                 w2_z_ready;
    logic [POUT_W-1:0]    w2_out_data;
    logic                 w2_out_valid;
    logic                 w2_out_last;
    logic [1:0]           w2_in_tile_cnt;
    logic [1:0]           w2_out_tile_cnt;

    wino_pad_bridge #(
        .DW(DW), .N_IN(N_IN), .N_OUT(N_OUT), .PIN_W(PIN_W),
        .POUT_W(POUT_W), .OUT_DEPTH(OUT_DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .d_tile(d_tile), .d_valid(d_valid), .d_ready(d_ready),
        .z_tile(z_tile), .z_valid(z_valid), .z_ready(z_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .in_tile_cnt(in_tile_cnt), .out_tile_cnt(out_tile_cnt)
    );

    wino_pad_bridge #(
        .DW(DW), .N_IN(N_IN), .N_OUT(N_OUT), .PIN_W(PIN_W),
        .POUT_W(POUT_W), .OUT_DEPTH(OUT_DEPTH), .CNT_W(2)
    ) dut_w2 (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(in_valid), .in_data(in_data), .in_ready(w2_in_ready),
        .d_tile(w2_d_tile), .d_valid(w2_d_valid), .d_ready(d_ready),
        .z_tile(z_tile), .z_valid(z_valid), .z_ready(w2_z_ready),
        .out_data(w2_out_data), .out_valid(w2_out_valid), .out_ready(out_ready),
        .out_last(w2_out_last), .in_tile_cnt(w2_in_tile_cnt), .out_tile_cnt(w2_out_tile_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model state
    int                   m_beats;
    logic [DW*N_IN-1:0]   m_tile;
    logic [DW*N_OUT-1:0]  m_q[$];
    int                   m_j;
    int                   m_in_cnt;
    int                   m_out_cnt;

    int n_vec;
    int n_err;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_beats   = 0;
        m_tile    = '0;
        m_q.delete();
        m_j       = 0;
        m_in_cnt  = 0;
        m_out_cnt = 0;
    endtask

    // compare every observable output against the model
    task automatic compare_model();
        logic [DW*N_OUT-1:0] h;
        logic [POUT_W-1:0]   exp_data;
        logic                nonempty;
        nonempty = (m_q.size() > 0);
        h        = nonempty ? m_q[0] : '0;
        exp_data = nonempty ? h[m_j*POUT_W +: POUT_W] : '0;
        chk("in_ready",  64'(in_ready),  64'(m_beats < IN_BEATS));
        chk("d_valid",   64'(d_valid),   64'(m_beats == IN_BEATS));
        if (m_beats == IN_BEATS) chk("d_tile", 64'(d_tile), 64'(m_tile));
        chk("z_ready",   64'(z_ready),   64'(m_q.size() < OUT_DEPTH));
        chk("out_valid", 64'(out_valid), 64'(nonempty));
        chk("out_data",  64'(out_data),  64'(exp_data));
        chk("out_last",  64'(out_last),  64'(nonempty && (m_j == OUT_BEATS - 1)));
        chk("in_cnt",    64'(in_tile_cnt),  64'(m_in_cnt % 65536));
        chk("out_cnt",   64'(out_tile_cnt), 64'(m_out_cnt % 65536));
        chk("in_cnt_w2", 64'(w2_in_tile_cnt), 64'(m_in_cnt % 4));
    endtask

    // drive one cycle of inputs, advance the model, then check after the edge
    task automatic tick(input logic t_clr, input logic t_iv, input logic [PIN_W-1:0] t_id,
                        input logic t_dr, input logic [DW*N_OUT-1:0] t_zt,
                        input logic t_zv, input logic t_or);
        logic push_ok;
        clr       = t_clr;
        in_valid  = t_iv;
        in_data   = t_id;
        d_ready   = t_dr;
        z_tile    = t_zt;
        z_valid   = t_zv;
        out_ready = t_or;
        if (t_clr) begin
            model_reset();
        end else begin
            push_ok = t_zv && (m_q.size() < OUT_DEPTH);
            if (m_beats < IN_BEATS) begin
                if (t_iv) begin
                    m_tile[m_beats*PIN_W +: PIN_W] = t_id;
                    m_beats++;
                end
            end else if (t_dr) begin
                m_beats = 0;
                m_in_cnt++;
            end
            if ((m_q.size() > 0) && t_or) begin
                m_j++;
                if (m_j == OUT_BEATS) begin
                    m_j = 0;
                    void'(m_q.pop_front());
                    m_out_cnt++;
                end
            end
            if (push_ok) m_q.push_back(t_zt);
        end
        @(negedge clk);
        compare_model();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; d_ready = 1'b0;
        z_tile = '0; z_valid = 1'b0; out_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        compare_model();
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_d_tile",   64'(d_tile),   64'd0);

        // input deserialisation with the core stalled
        tick(0, 1, 20'h00001, 0, '0, 0, 0);
        tick(0, 1, 20'h00002, 0, '0, 0, 0);
        tick(0, 1, 20'h00003, 0, '0, 0, 0);
        chk("t1_d_valid",  64'(d_valid),  64'd1);
        chk("t1_d_tile",   64'(d_tile),   64'h000030000200001);
        chk("t1_in_ready", 64'(in_ready), 64'd0);
        tick(0, 0, '0, 1, '0, 0, 0);
        chk("t1_in_cnt",   64'(in_tile_cnt), 64'd1);
        chk("t1_ready_back", 64'(in_ready),  64'd1);

        // single tile serialised
        tick(0, 0, '0, 0, 20'hABCDE, 1, 1);
        chk("t2_beat0", 64'(out_data), 64'h0DE);
        chk("t2_last0", 64'(out_last), 64'd0);
        tick(0, 0, '0, 0, '0, 0, 1);
        chk("t2_beat1", 64'(out_data), 64'h2AF);
        chk("t2_last1", 64'(out_last), 64'd1);
        tick(0, 0, '0, 0, '0, 0, 1);
        chk("t2_out_cnt", 64'(out_tile_cnt), 64'd1);

        // backpressure, then push against a full FIFO while it pops
        tick(0, 0, '0, 0, 20'h11111, 1, 0);
        tick(0, 0, '0, 0, 20'h22222, 1, 0);
        chk("t3_full",  64'(z_ready),  64'd0);
        tick(0, 0, '0, 0, '0, 0, 0);
        chk("t3_hold",  64'(out_data), 64'h111);
        tick(0, 0, '0, 0, '0, 0, 1);
        tick(0, 0, '0, 0, 20'h33333, 1, 1);
        chk("t3_ready_after_pop", 64'(z_ready), 64'd1);
        tick(0, 0, '0, 0, 20'h33333, 1, 0);
        repeat (5) tick(0, 0, '0, 0, '0, 0, 1);

        // clr mid-tile and with a FIFO entry pending
        tick(0, 1, 20'h12345, 0, 20'h44444, 1, 0);
        tick(0, 1, 20'h6789A, 0, '0, 0, 0);
        tick(1, 1, 20'hFFFFF, 1, 20'h55555, 1, 1);
        chk("t4_d_valid",  64'(d_valid),   64'd0);
        chk("t4_out_valid", 64'(out_valid), 64'd0);
        chk("t4_out_cnt",  64'(out_tile_cnt), 64'd0);
        tick(0, 1, 20'h11111, 0, '0, 0, 0);
        tick(0, 1, 20'h22222, 0, '0, 0, 0);
        tick(0, 1, 20'h33333, 0, '0, 0, 0);
        chk("t4_clean_tile", 64'(d_tile), 64'h333332222211111);
        tick(0, 0, '0, 1, '0, 0, 0);

        // asynchronous reset during serialisation (j = 1)
        tick(0, 0, '0, 0, 20'h6A5F0, 1, 1);
        tick(0, 0, '0, 0, '0, 0, 1);
        chk("t5_mid_last", 64'(out_last), 64'd1);
        #2 rst = 1'b0;
        #1;
        chk("t5_async_out_valid", 64'(out_valid), 64'd0);
        chk("t5_async_out_data",  64'(out_data),  64'd0);
        chk("t5_async_in_cnt",    64'(in_tile_cnt), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        #1;
        compare_model();

        // five tiles into the 2-bit counter instance
        for (int t = 0; t < 5; t++) begin
            for (int b = 0; b < IN_BEATS; b++) tick(0, 1, 20'($urandom), 0, '0, 0, 0);
            tick(0, 0, '0, 1, '0, 0, 0);
        end
        chk("t6_wrap_cnt", 64'(w2_in_tile_cnt), 64'd1);
        chk("t6_full_cnt", 64'(in_tile_cnt),    64'd5);

        // randomized traffic on both paths
        for (int i = 0; i < 3000; i++) begin
            tick(($urandom_range(0, 63) == 0), 1'($urandom), 20'($urandom),
                 1'($urandom), 20'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wino_pad_bridge.md
Name: wino_pad_bridge

Overview:
- Parametrised pad-side bridge between narrow chip I/O pads and the Winograd core tile ports.
- Input side: deserialises PIN_W-bit pad beats into one N_IN×DW-bit input tile, with a valid/ready handshake toward the core.
- Output side: buffers core output tiles of N_OUT×DW bits in a small FIFO and serialises them onto POUT_W-bit pads.
- Replaces the direct 60-bit-in / 20-bit-out pad wiring so wider tiles and more channels fit a fixed pad count.

Parameters:
DW, 10, bits per tile element
N_IN, 6, elements per input tile (D tile)
N_OUT, 2, elements per output tile (Z tile)
PIN_W, 20, input pad beat width; DW*N_IN must be a multiple of PIN_W
POUT_W, 10, output pad beat width; DW*N_OUT must be a multiple of POUT_W
OUT_DEPTH, 2, output tile FIFO depth; power of two, ≥2
CNT_W, 16, tile counter width

Ports:
clk  in  1  clock, all logic rising-edge
rst  in  1  reset, asynchronous assert, active-low
clr  in  1  synchronous flush, active-high
in_valid  in  1  pad input beat valid
in_data  in  PIN_W  pad input beat
in_ready  out  1  bridge accepts input beat
d_tile  out  DW*N_IN  assembled tile to core
d_valid  out  1  d_tile valid
d_ready  in  1  core accepts d_tile
z_tile  in  DW*N_OUT  result tile from core
z_valid  in  1  z_tile valid
z_ready  out  1  FIFO not full
out_data  out  POUT_W  pad output beat
out_valid  out  1  out_data valid
out_ready  in  1  pad side accepts beat
out_last  out  1  final beat of a tile
in_tile_cnt  out  CNT_W  tiles delivered to core
out_tile_cnt  out  CNT_W  tiles fully sent on pads

Behaviour:
- Transfer rule: a beat or tile transfers on a rising clk edge when valid and ready are both 1.
- Derived constants: IN_BEATS = DW*N_IN/PIN_W (default 3); OUT_BEATS = DW*N_OUT/POUT_W (default 2).
- Reset (rst=0, asynchronous) and clr=1 (synchronous) both produce:
  - in_ready=1, z_ready=1.
  - d_valid=0, d_tile=0.
  - out_valid=0, out_data=0, out_last=0.
  - Both counters 0; FIFO empty; beat counters 0; input FSM in COLLECT.
- clr has priority over every handshake in the same cycle. Any partial tile and all FIFO contents are discarded.
- Input FSM, COLLECT:
  - in_ready=1; d_valid=0.
  - Beat k (0-based) is written to d_tile[k*PIN_W +: PIN_W], i.e. LSB-first.
  - Accepting beat IN_BEATS-1 moves the FSM to HOLD.
- Input FSM, HOLD:
  - in_ready=0; d_valid=1; d_tile stays stable.
  - On a d_valid&d_ready transfer: go to COLLECT, increment in_tile_cnt, reset the beat counter.
  - in_ready returns to 1 on the cycle after the transfer; there is no same-cycle bypass.
- Input latency: d_valid rises on the cycle after the last beat is accepted.
- Output FIFO push:
  - z_ready = !full, taken from registered state only.
  - A push while full cannot occur.
  - Push and pop in the same cycle are both honoured.
- Output serialiser:
  - out_valid=1 whenever the FIFO is non-empty.
  - out_data = head[j*POUT_W +: POUT_W], where j is the output beat counter.
  - out_last=1 when j=OUT_BEATS-1.
  - On out_valid&out_ready: j increments. On the last beat: j→0, head pops, out_tile_cnt increments.
  - out_data and out_last hold stable while out_valid=1 and out_ready=0.
- Output latency: the first beat of a tile pushed into an empty FIFO appears on the cycle after the push.
- Counters wrap modulo 2^CNT_W with no saturation.
- FIFO pointers wrap modulo OUT_DEPTH. Full/empty are distinguished by an extra pointer bit.
- Input and output paths are independent and may be active in the same cycle.

Test Plan:
- Reset then 3 input beats 0x00001, 0x00002, 0x00003 with d_ready=0.
  - Required: d_valid=1 the cycle after beat 3; d_tile=0x000030000200001; in_ready=0.
  - Then d_ready=1: in_tile_cnt=1 and in_ready=1 the next cycle.
- Push z_tile=0xABCDE with out_ready=1.
  - Required: out_data=0x0DE (out_last=0), then 0x2AF (out_last=1); out_tile_cnt=1.
- Output backpressure: out_ready=0, push 2 tiles.
  - Required: z_ready=0 after the 2nd push; out_data stays held.
  - Then release out_ready=1: 4 beats in push order; z_ready=1 after the first pop.
- Simultaneous push/pop with the FIFO full.
  - Required: z_ready stays 0 that cycle; the pop completes, then the push is accepted next cycle; no tile is lost or duplicated.
- Assert clr after 2 of 3 input beats and with 1 tile in the FIFO.
  - Required: next cycle d_valid=0, out_valid=0, counters 0.
  - A following 3-beat input builds a clean tile with no stale bits.
- Assert rst low mid-serialisation (j=1).
  - Required: out_valid=0 immediately, without waiting for a clock edge; after release, all outputs are at their reset values.
- Counter wrap: set CNT_W=2 and deliver 5 input tiles.
  - Required: in_tile_cnt=1.
